// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared types and constants for the round-robin dispatcher
package dispatcher_pkg;
  typedef enum logic {SEL_0, SEL_1} sel_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/dispatcher_2_rr_stream_buf.sv
// stream_buf_2: 2-entry registered FIFO with valid/ready-style push and pop
module stream_buf_2
  import dispatcher_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] data_in,
  output logic              space,
  output logic              valid,
  output logic [DWIDTH-1:0] data_out,
  input  logic              pop
);
  logic [1:0] count;
  logic [DWIDTH-1:0] tail;
  logic do_push, do_pop;
  always_comb begin
    space = count < 2'(BUF_DEPTH);
    valid = count != 2'd0;
    do_push = push && space;
    do_pop = pop && valid;
  end
  always_ff @(posedge clk) begin
    if (rst) count <= 2'd0;
    else count <= count + {1'b0, do_push} - {1'b0, do_pop};
  end
  // Head is loaded on an empty push, a push replacing a leaving head, or a shift from tail.
  always_ff @(posedge clk) begin
    if (do_pop && count == 2'd2) data_out <= tail;
    else if (do_push && (count == 2'd0 || do_pop)) data_out <= data_in;
    if (do_push && count == 2'd1 && !do_pop) tail <= data_in;
  end
endmodule

// File: rtl/dispatcher_2_rr.sv
// dispatcher_2_rr: round-robin 1-to-2 stream dispatcher skipping full outputs
module dispatcher_2_rr
  import dispatcher_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter bit PRIORITY_0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_0_valid,
  output logic [DWIDTH-1:0] out_0_data,
  input  logic              out_0_ready,
  output logic              out_1_valid,
  output logic [DWIDTH-1:0] out_1_data,
  input  logic              out_1_ready
);
  localparam sel_t LAST_RST = PRIORITY_0 ? SEL_1 : SEL_0;
  sel_t last_sel, pick;
  logic space_0, space_1, accept;
  always_comb begin
    in_ready = !rst && (space_0 || space_1);
    accept = in_valid && in_ready;
    pick = (space_0 && space_1) ? ((last_sel == SEL_0) ? SEL_1 : SEL_0)
         : (space_0 ? SEL_0 : SEL_1);
  end
  always_ff @(posedge clk) begin
    if (rst) last_sel <= LAST_RST;
    else if (accept) last_sel <= pick;
  end
  stream_buf_2 #(.DWIDTH(DWIDTH)) u_buf_0 (
    .clk(clk), .rst(rst), .push(accept && pick == SEL_0), .data_in(in_data),
    .space(space_0), .valid(out_0_valid), .data_out(out_0_data), .pop(out_0_ready)
  );
  stream_buf_2 #(.DWIDTH(DWIDTH)) u_buf_1 (
    .clk(clk), .rst(rst), .push(accept && pick == SEL_1), .data_in(in_data),
    .space(space_1), .valid(out_1_valid), .data_out(out_1_data), .pop(out_1_ready)
  );
endmodule

// File: tb/tb_dispatcher_2_rr.sv
// tb_dispatcher_2_rr: directed self-checking bench for dispatcher_2_rr
module tb_dispatcher_2_rr;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_0_valid, out_0_ready, out_1_valid, out_1_ready;
  logic [15:0] in_data, out_0_data, out_1_data;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dispatcher_2_rr #(.DWIDTH(16), .PRIORITY_0(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_0_valid(out_0_valid), .out_0_data(out_0_data), .out_0_ready(out_0_ready),
    .out_1_valid(out_1_valid), .out_1_data(out_1_data), .out_1_ready(out_1_ready)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0; out_0_ready = 1'b1; out_1_ready = 1'b1;
    // reset held two cycles with in_valid high
    cyc(); #1;
    chk("rst_ready_a", in_ready, 0); chk("rst_v0_a", out_0_valid, 0); chk("rst_v1_a", out_1_valid, 0);
    cyc(); #1;
    chk("rst_ready_b", in_ready, 0); chk("rst_v0_b", out_0_valid, 0); chk("rst_v1_b", out_1_valid, 0);
    // alternation
    rst = 1'b0; in_data = 16'hDEAD; #1;
    chk("rel_ready", in_ready, 1);
    cyc(); in_data = 16'hBEEF; #1;
    chk("alt_v0_1", out_0_valid, 1); chk("alt_d0_1", out_0_data, 16'hDEAD); chk("alt_v1_1", out_1_valid, 0);
    cyc(); in_data = 16'hCAFE; #1;
    chk("alt_v0_2", out_0_valid, 0); chk("alt_v1_2", out_1_valid, 1); chk("alt_d1_2", out_1_data, 16'hBEEF);
    cyc(); in_data = 16'hF00D; #1;
    chk("alt_v0_3", out_0_valid, 1); chk("alt_d0_3", out_0_data, 16'hCAFE); chk("alt_v1_3", out_1_valid, 0);
    cyc(); in_valid = 1'b0; #1;
    chk("alt_v0_4", out_0_valid, 0); chk("alt_v1_4", out_1_valid, 1); chk("alt_d1_4", out_1_data, 16'hF00D);
    cyc(); #1;
    chk("alt_v0_5", out_0_valid, 0); chk("alt_v1_5", out_1_valid, 0);
    // fill out_1 with A0..D0 pattern while out_0 drains, then skip it
    out_1_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A0;
    cyc(); in_data = 16'h00B0;
    cyc(); in_data = 16'h00C0;
    cyc(); in_data = 16'h00D0; #1;
    chk("skip_d1_pre", out_1_data, 16'h00B0);
    cyc(); out_0_ready = 1'b0; in_data = 16'h0001; #1;
    chk("skip_v1_full", out_1_valid, 1); chk("skip_ready_a", in_ready, 1);
    cyc(); in_data = 16'h0002; #1;
    chk("skip_d0_1", out_0_data, 16'h0001); chk("skip_ready_b", in_ready, 1);
    cyc(); in_data = 16'h0003; #1;
    chk("skip_hold_a", in_ready, 0); chk("skip_d0_hold", out_0_data, 16'h0001); chk("skip_d1_hold", out_1_data, 16'h00B0);
    cyc(); #1;
    chk("skip_hold_b", in_ready, 0);
    out_1_ready = 1'b1;
    cyc(); #1;
    chk("skip_ready_c", in_ready, 1); chk("skip_d1_next", out_1_data, 16'h00D0);
    cyc(); in_valid = 1'b0; out_0_ready = 1'b1; #1;
    chk("skip_v1_3", out_1_valid, 1); chk("skip_d1_3", out_1_data, 16'h0003); chk("skip_d0_keep", out_0_data, 16'h0001);
    cyc(); #1;
    chk("skip_d0_2", out_0_data, 16'h0002); chk("skip_v1_drained", out_1_valid, 0);
    cyc(); #1;
    chk("skip_v0_end", out_0_valid, 0); chk("skip_v1_end", out_1_valid, 0);
    // full stall
    out_0_ready = 1'b0; out_1_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
    cyc(); in_data = 16'h0011;
    cyc(); in_data = 16'h0012;
    cyc(); in_data = 16'h0013;
    cyc(); in_valid = 1'b0; #1;
    chk("stall_ready", in_ready, 0); chk("stall_d0", out_0_data, 16'h0010); chk("stall_d1", out_1_data, 16'h0011);
    out_0_ready = 1'b1;
    cyc(); out_0_ready = 1'b0; #1;
    chk("stall_ready_up", in_ready, 1); chk("stall_d0_pop", out_0_data, 16'h0012);
    cyc(); #1;
    chk("stall_ready_keep", in_ready, 1); chk("stall_d0_keep", out_0_data, 16'h0012); chk("stall_d1_keep", out_1_data, 16'h0011);
    out_0_ready = 1'b1; out_1_ready = 1'b1;
    cyc(); #1;
    chk("stall_d1_13", out_1_data, 16'h0013); chk("stall_v0_0", out_0_valid, 0);
    cyc(); #1;
    chk("stall_v0_end", out_0_valid, 0); chk("stall_v1_end", out_1_valid, 0);
    // push and pop together on out_0 at count 1
    out_0_ready = 1'b0; out_1_ready = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA;
    cyc(); in_data = 16'h5555;
    cyc(); in_data = 16'hBBBB; out_0_ready = 1'b1; #1;
    chk("pp_d0_a", out_0_data, 16'hAAAA);
    cyc(); in_valid = 1'b0; out_0_ready = 1'b0; #1;
    chk("pp_v0_b", out_0_valid, 1); chk("pp_d0_b", out_0_data, 16'hBBBB);
    cyc(); #1;
    chk("pp_d0_hold", out_0_data, 16'hBBBB); chk("pp_d1", out_1_data, 16'h5555);
    out_0_ready = 1'b1;
    cyc(); #1;
    chk("pp_v0_once", out_0_valid, 0);
    // reset mid-operation with last_sel at SEL_0
    out_0_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
    cyc(); in_data = 16'h8888;
    cyc(); in_valid = 1'b0; #1;
    chk("mid_v0_pre", out_0_valid, 1); chk("mid_d0_pre", out_0_data, 16'h8888);
    rst = 1'b1; #1;
    chk("mid_rst_ready", in_ready, 0);
    cyc(); rst = 1'b0; in_valid = 1'b1; in_data = 16'h1234; #1;
    chk("mid_v0", out_0_valid, 0); chk("mid_v1", out_1_valid, 0); chk("mid_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    chk("mid_v0_new", out_0_valid, 1); chk("mid_d0_new", out_0_data, 16'h1234); chk("mid_v1_new", out_1_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dispatcher_2_rr.md
# dispatcher_2_rr

Round-robin 1-to-2 stream dispatcher: takes one valid/ready input stream and spreads each accepted word to one of two output streams, alternating between the outputs and skipping a back-pressured one. It is the fan-out counterpart of the 2-input round-robin arbiter. It sits in front of a pair of identical downstream engines so that work is load-balanced across them. Each output has a 2-entry buffer, so one slow consumer never stalls the other while it still has space.

## Interface
- DWIDTH, 16, data word width in bits
- PRIORITY_0, 1, target of the first word after reset: 1 → out_0, 0 → out_1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_data  in  DWIDTH  input word
- in_ready  out  1  dispatcher accepts in_data this cycle
- out_0_valid  out  1  buffer 0 head valid
- out_0_data  out  DWIDTH  buffer 0 head word
- out_0_ready  in  1  consumer 0 takes the head
- out_1_valid  out  1  buffer 1 head valid
- out_1_data  out  DWIDTH  buffer 1 head word
- out_1_ready  in  1  consumer 1 takes the head

## Operation
- Two output buffers, each FIFO depth 2, with count 0..2. space_x = (count_x < 2).
- in_ready = !rst && (space_0 || space_1). It depends only on registered state, with no combinational path from out_x_ready. Pops in the same cycle do not create space until the next cycle.
- Selection, evaluated when in_valid && in_ready:
  - If both outputs have space, pick the output != last_sel.
  - If only one has space, pick that one.
- last_sel updates to the chosen output only on an accepted transfer. A stall or idle cycle keeps the pointer.
- Reset value of last_sel is chosen so the first pick is out_0 when PRIORITY_0=1 and out_1 otherwise.
- out_x_valid = (count_x != 0). out_x_data = head entry, driven from a register.
- Pop on out_x_valid && out_x_ready.
- Per-buffer push and pop in the same cycle:
  - count 1: count stays 1, old head leaves, new word becomes head.
  - count 2: push is impossible because in_ready excludes that buffer.
  - count 0: no bypass. The word appears next cycle.
- Word order is preserved within each output. There is no ordering guarantee across outputs.
- Reset (any cycle, including mid-burst):
  - Both counts go to 0, which flushes any buffered words.
  - last_sel returns to its reset value.
  - Outputs after reset: in_ready=0 while rst=1; out_0_valid=0, out_1_valid=0. out_x_data value is don't-care.

## Timing
- Latency: a word accepted at posedge t is visible on out_x_valid/out_x_data from posedge t+1.
- Throughput: 1 word/cycle sustained while at least one output drains. Each output sustains 1 word/cycle when its own ready stays high.
- in_ready drops the cycle after both buffers reach count 2. It rises the cycle after any pop.
- in_data/in_valid are sampled only when in_ready=1. Holding in_valid while in_ready=0 is legal and loses nothing.
- Outputs obey valid/ready: once out_x_valid=1, valid and data hold until popped or reset.

## Structure
- Shared package dispatcher_pkg: typedef enum logic {SEL_0, SEL_1} sel_t, used for last_sel and the pick. Also holds localparam BUF_DEPTH = 2.
- Sub-module stream_buf_2 (DWIDTH): 2-entry FIFO with push, data_in, space, valid, data_out, pop. It is instantiated twice.
- Top level contains only the selection logic and the last_sel register.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → in_ready=0, out_0_valid=0, out_1_valid=0. On the first cycle after release, in_ready=1.
- Alternation: PRIORITY_0=1, both out_x_ready=1, stream 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D → out_0 emits DEAD then CAFE, out_1 emits BEEF then F00D. Each word appears 1 cycle after acceptance.
- Skip back-pressured output: out_1_ready=0 and buffer 1 full (count 2), stream 16'h0001, 16'h0002, 16'h0003 → 0001 and 0002 go to out_0. 0003 is held (in_ready=0) until out_1_ready=1 or out_0 pops.
- Full stall: both ready=0, push 4 words 16'h0010..16'h0013 → accepted as 10/12 on out_0 and 11/13 on out_1, then in_ready=0. Raising out_0_ready for one cycle → 10 popped, and in_ready=1 the following cycle.
- Simultaneous push/pop at count 1: out_0 holds 16'hAAAA with ready=1 while 16'hBBBB is dispatched to out_0 → next cycle out_0_data=BBBB with count 1, and no word is lost or duplicated.
- Reset mid-operation: both buffers holding data and last_sel=SEL_0, assert rst 1 cycle → both valids go to 0. The next accepted word 16'h1234 goes to out_0 (PRIORITY_0=1).
